// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and the multi-cycle ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             sign_flag;
    logic             carry_flag;
    logic             overflow_flag;

    modport master (output start, op, a, b,
                    input  busy, done, result, zero_flag, sign_flag, carry_flag, overflow_flag);
    modport slave  (input  start, op, a, b,
                    output busy, done, result, zero_flag, sign_flag, carry_flag, overflow_flag);
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle integer ops plus an iterative shift-add multiplier
// and restoring divider sharing one 2*WIDTH accumulator.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } rsp_t;

    state_t             state, state_nxt;
    logic [SHW-1:0]     cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc, acc_nxt, acc_mul, acc_div;
    logic [WIDTH-1:0]   res_q, it_res;
    logic               done_q, zero_q, sign_q, carry_q, ovf_q;
    logic               accept, iter_in, fin;

    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_w, sub_w, psum, rsh, rdif;
    logic               qbit;
    rsp_t               sc;

    assign iter_in = (bus.op[3:2] == 2'b11);
    assign accept  = bus.start && (state == IDLE);
    assign fin     = (state == RUN) && (cnt == SHW'(WIDTH - 1));

    assign sh    = bus.b[SHW-1:0];
    assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        sc = '0;
        case (bus.op)
            4'b0000: begin
                sc.res = add_w[WIDTH-1:0];
                sc.c   = add_w[WIDTH];
                sc.v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0001: sc.res = bus.a << sh;
            4'b0010: begin
                sc.res = sub_w[WIDTH-1:0];
                sc.c   = sub_w[WIDTH];
                sc.v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0011: sc.res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b0100: sc.res = bus.a ^ bus.b;
            4'b0101: sc.res = bus.a >> sh;
            4'b0110: sc.res = bus.a | bus.b;
            4'b0111: sc.res = bus.a & bus.b;
            4'b1000: sc.res = $unsigned($signed(bus.a) >>> sh);
            4'b1001: sc.res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: sc = '0;
        endcase
    end

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    always_comb begin
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        acc_mul = {psum, acc[WIDTH-1:1]};
        rsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rdif    = rsh - {1'b0, opnd_q};
        qbit    = ~rdif[WIDTH];
        acc_div = {(qbit ? rdif[WIDTH-1:0] : rsh[WIDTH-1:0]), acc[WIDTH-2:0], qbit};
        acc_nxt = op_q[1] ? acc_div : acc_mul;
        it_res  = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && iter_in) state_nxt = RUN;
            RUN:  if (fin)               state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc     <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && !iter_in) begin
                res_q   <= sc.res;
                zero_q  <= (sc.res == '0);
                sign_q  <= sc.res[WIDTH-1];
                carry_q <= sc.c;
                ovf_q   <= sc.v;
                done_q  <= 1'b1;
            end else if (accept) begin
                op_q   <= bus.op;
                opnd_q <= bus.op[1] ? bus.b : bus.a;
                acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? bus.a : bus.b)};
                cnt    <= '0;
            end else if (state == RUN) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (fin) begin
                    res_q   <= it_res;
                    zero_q  <= (it_res == '0);
                    sign_q  <= it_res[WIDTH-1];
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy          = (state == RUN);
    assign bus.done          = done_q;
    assign bus.result        = res_q;
    assign bus.zero_flag     = zero_q;
    assign bus.sign_flag     = sign_q;
    assign bus.carry_flag    = carry_q;
    assign bus.overflow_flag = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8 with directed vectors.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) b32 ();
    alu_seq_if #(.WIDTH(8))  b8  ();

    alu_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
    alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;   // {zero, sign, carry, overflow}
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   nd32 = 0;
    int   nd8 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (b32.done === 1'b1) begin
            nd32++;
            if (q32.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done32_unexpected: got done=1, want no done (result 0x%0h)", b32.result);
            end else begin
                e = q32.pop_front();
                chk("result32", {32'b0, b32.result}, {32'b0, e.r});
                chk("flags32", {60'b0, b32.zero_flag, b32.sign_flag, b32.carry_flag, b32.overflow_flag},
                    {60'b0, e.f});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b8.done === 1'b1) begin
            nd8++;
            if (q8.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done8_unexpected: got done=1, want no done (result 0x%0h)", b8.result);
            end else begin
                e = q8.pop_front();
                chk("result8", {56'b0, b8.result}, {32'b0, e.r});
                chk("flags8", {60'b0, b8.zero_flag, b8.sign_flag, b8.carry_flag, b8.overflow_flag},
                    {60'b0, e.f});
            end
        end
    end

    task automatic go32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        b32.start = 1'b1;
        b32.op    = op;
        b32.a     = a;
        b32.b     = b;
        if (push) begin
            e.r = er;
            e.f = ef;
            q32.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic it32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef);
        int nb;
        go32(op, a, b, 1'b1, er, ef);
        b32.start = 1'b0;
        nb = 0;
        while (b32.busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("latency32", 64'(nb), 64'd32);
    endtask

    task automatic go8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef);
        exp_t e;
        b8.start = 1'b1;
        b8.op    = op;
        b8.a     = a;
        b8.b     = b;
        e.r = {24'b0, er};
        e.f = ef;
        q8.push_back(e);
        @(negedge clk);
    endtask

    task automatic it8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef);
        int nb;
        go8(op, a, b, er, ef);
        b8.start = 1'b0;
        nb = 0;
        while (b8.busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("latency8", 64'(nb), 64'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        int d0;
        int nb;
        b32.start = 1'b0; b32.op = '0; b32.a = '0; b32.b = '0;
        b8.start  = 1'b0; b8.op  = '0; b8.a  = '0; b8.b  = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", {63'b0, b32.busy}, 64'd0);
        chk("rst_done", {63'b0, b32.done}, 64'd0);
        chk("rst_result", {32'b0, b32.result}, 64'd0);
        chk("rst_flags", {60'b0, b32.zero_flag, b32.sign_flag, b32.carry_flag, b32.overflow_flag}, 64'd0);
        chk("rst_result8", {56'b0, b8.result}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle sweep, issued back to back
        go32(4'b0000, 32'hFFFF_FFFF, 32'h1,         1, 32'h0,         4'b1010);
        go32(4'b0010, 32'h8000_0000, 32'h1,         1, 32'h7FFF_FFFF, 4'b0001);
        go32(4'b1000, 32'h8000_0000, 32'h4,         1, 32'hF800_0000, 4'b0100);
        go32(4'b0101, 32'h8000_0000, 32'h4,         1, 32'h0800_0000, 4'b0000);
        go32(4'b0011, 32'hFFFF_FFFF, 32'h1,         1, 32'h1,         4'b0000);
        go32(4'b1001, 32'hFFFF_FFFF, 32'h1,         1, 32'h0,         4'b1000);
        go32(4'b0000, 32'h7FFF_FFFF, 32'h1,         1, 32'h8000_0000, 4'b0101);
        go32(4'b0010, 32'h1,         32'h2,         1, 32'hFFFF_FFFF, 4'b0110);
        go32(4'b0001, 32'h4000_0001, 32'd33,        1, 32'h8000_0002, 4'b0100);
        go32(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 4'b0100);
        go32(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 4'b0000);
        go32(4'b0110, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 4'b0000);
        go32(4'b1010, 32'h5,         32'h6,         1, 32'h0,         4'b1000);
        b32.start = 1'b0;
        @(negedge clk);

        // Multiply: single done pulse, 32-cycle busy
        d0 = nd32;
        it32(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0000);
        @(negedge clk);
        chk("mul_done_pulses", 64'(nd32 - d0), 64'd1);
        chk("mul_done_low", {63'b0, b32.done}, 64'd0);
        it32(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100);
        @(negedge clk);

        // Reset ten cycles into a MUL aborts it with no done
        go32(4'b1100, 32'd3, 32'd5, 0, 32'h0, 4'b0000);
        b32.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_mul_busy", {63'b0, b32.busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'b0, b32.busy}, 64'd0);
        chk("abort_result", {32'b0, b32.result}, 64'd0);
        chk("abort_done", {63'b0, b32.done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        it32(4'b1110, 32'd100, 32'd7, 32'd14, 4'b0000);
        @(negedge clk);

        // Divide by zero and remainder
        it32(4'b1110, 32'd1234, 32'd0, 32'hFFFF_FFFF, 4'b0100);
        it32(4'b1111, 32'd1234, 32'd0, 32'd1234,      4'b0000);
        it32(4'b1111, 32'd100,  32'd7, 32'd2,         4'b0000);
        @(negedge clk);

        // start while busy is ignored and operands are not re-latched
        d0 = nd32;
        go32(4'b1110, 32'd100, 32'd7, 1, 32'd14, 4'b0000);
        go32(4'b0000, 32'd1, 32'd2, 0, 32'h0, 4'b0000);
        go32(4'b0000, 32'd1, 32'd2, 0, 32'h0, 4'b0000);
        chk("hold_result_busy", {32'b0, b32.result}, 64'd2);
        chk("hold_busy", {63'b0, b32.busy}, 64'd1);
        b32.start = 1'b0;
        nb = 0;
        while (b32.busy === 1'b1 && nb < 100) begin
            nb++;
            @(negedge clk);
        end
        chk("busy_bound", 64'(nb < 100), 64'd1);
        @(negedge clk);
        chk("busy_ignore_pulses", 64'(nd32 - d0), 64'd1);

        // Three ADDs back to back keep done high for three cycles
        d0 = nd32;
        go32(4'b0000, 32'd1,         32'd2,         1, 32'd3,         4'b0000);
        go32(4'b0000, 32'd10,        32'd20,        1, 32'd30,        4'b0000);
        go32(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 4'b0110);
        b32.start = 1'b0;
        @(negedge clk);
        chk("b2b_done_count", 64'(nd32 - d0), 64'd3);
        chk("b2b_done_low", {63'b0, b32.done}, 64'd0);

        // WIDTH=8 instance
        it8(4'b1100, 8'h10, 8'h10, 8'h00, 4'b1000);
        it8(4'b1101, 8'h10, 8'h10, 8'h01, 4'b0000);
        go8(4'b0001, 8'h01, 8'd9,  8'h02, 4'b0000);
        b8.start = 1'b0;
        @(negedge clk);
        it8(4'b1110, 8'd200, 8'd10, 8'd20, 4'b0000);
        it8(4'b1111, 8'd200, 8'd0,  8'd200, 4'b0100);

        repeat (3) @(negedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
